// File: rtl/ahbl_gf_sram_ctrl_pkg.sv
// Shared encodings, SRAM geometry and byte-lane decode for the AHB-Lite
// front end of the 2 KiB GF180 SRAM bank.
package ahbl_gf_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam int SRAM_DEPTH = 512;
    localparam int N_LANES    = 4;
    localparam int SRAM_AW    = $clog2(SRAM_DEPTH);

    function automatic logic [N_LANES-1:0] lane_mask(input logic [2:0] size,
                                                     input logic [1:0] addr);
        logic [N_LANES-1:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr;
            HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] mask_to_bits(input logic [N_LANES-1:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/ahbl_gf_sram_ctrl.sv
// Zero-wait-state AHB-Lite subordinate driving four byte-wide 512x8 macros;
// a one-entry write buffer defers writes that collide with a read address phase.
module ahbl_gf_sram_ctrl
    import ahbl_gf_sram_ctrl_pkg::*;
#(
    parameter int W_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [31:0]       ahbls_hwdata,
    output logic [31:0]       ahbls_hrdata,
    output logic              sram_cen,
    output logic              sram_gwen,
    output logic [31:0]       sram_wen,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [31:0]       sram_d,
    input  logic [31:0]       sram_q
);

    logic                 aph_vld_s;
    logic                 aph_read_s;
    logic                 aph_write_s;
    logic [SRAM_AW-1:0]   aph_addr_s;
    logic [N_LANES-1:0]   aph_mask_s;
    logic                 unused_s;

    logic                 dph_write_q, dph_write_d;
    logic [SRAM_AW-1:0]   dph_addr_q,  dph_addr_d;
    logic [N_LANES-1:0]   dph_mask_q,  dph_mask_d;
    logic                 wbuf_vld_q,  wbuf_vld_d;
    logic [SRAM_AW-1:0]   wbuf_addr_q, wbuf_addr_d;
    logic [N_LANES-1:0]   wbuf_mask_q, wbuf_mask_d;
    logic [31:0]          wbuf_data_q, wbuf_data_d;
    logic [N_LANES-1:0]   fwd_mask_q,  fwd_mask_d;

    // Gating with rst keeps the macros deselected while reset is held.
    assign aph_vld_s   = ~rst & ahbls_hready &
                         ((htrans_t'(ahbls_htrans) == HTRANS_NONSEQ) ||
                          (htrans_t'(ahbls_htrans) == HTRANS_SEQ));
    assign aph_read_s  = aph_vld_s & ~ahbls_hwrite;
    assign aph_write_s = aph_vld_s &  ahbls_hwrite;
    assign aph_addr_s  = ahbls_haddr[SRAM_AW+1:2];
    assign aph_mask_s  = lane_mask(ahbls_hsize, ahbls_haddr[1:0]);

    assign unused_s = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                        ahbls_haddr[W_ADDR-1:SRAM_AW+2]};

    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;

    assign ahbls_hrdata = (sram_q      & ~mask_to_bits(fwd_mask_q)) |
                          (wbuf_data_q &  mask_to_bits(fwd_mask_q));

    // SRAM port arbitration, write-buffer control and read-forward selection.
    always_comb begin
        dph_write_d = aph_write_s;
        dph_addr_d  = aph_addr_s;
        dph_mask_d  = aph_mask_s;
        wbuf_vld_d  = wbuf_vld_q;
        wbuf_addr_d = wbuf_addr_q;
        wbuf_mask_d = wbuf_mask_q;
        wbuf_data_d = wbuf_data_q;
        fwd_mask_d  = 4'b0000;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = 32'hFFFF_FFFF;
        sram_a      = aph_addr_s;
        sram_d      = ahbls_hwdata;

        if (aph_read_s) begin
            sram_cen = 1'b0;
            if (dph_write_q) begin
                wbuf_vld_d  = 1'b1;
                wbuf_addr_d = dph_addr_q;
                wbuf_mask_d = dph_mask_q;
                wbuf_data_d = ahbls_hwdata;
            end else begin
                wbuf_vld_d  = wbuf_vld_q;
            end
            if (wbuf_vld_q && (wbuf_addr_q == aph_addr_s)) begin
                fwd_mask_d = wbuf_mask_q;
            end else if (dph_write_q && (dph_addr_q == aph_addr_s)) begin
                fwd_mask_d = dph_mask_q;
            end else begin
                fwd_mask_d = 4'b0000;
            end
        end else if (wbuf_vld_q) begin
            sram_cen   = 1'b0;
            sram_gwen  = 1'b0;
            sram_wen   = ~mask_to_bits(wbuf_mask_q);
            sram_a     = wbuf_addr_q;
            sram_d     = wbuf_data_q;
            wbuf_vld_d = 1'b0;
        end else if (dph_write_q) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~mask_to_bits(dph_mask_q);
            sram_a    = dph_addr_q;
            sram_d    = ahbls_hwdata;
        end else begin
            sram_cen  = 1'b1;
            sram_gwen = 1'b1;
        end
    end

    // Data-phase, write-buffer and forwarding state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dph_write_q <= 1'b0;
            dph_addr_q  <= 9'd0;
            dph_mask_q  <= 4'b0000;
            wbuf_vld_q  <= 1'b0;
            wbuf_addr_q <= 9'd0;
            wbuf_mask_q <= 4'b0000;
            wbuf_data_q <= 32'h0000_0000;
            fwd_mask_q  <= 4'b0000;
        end else begin
            dph_write_q <= dph_write_d;
            dph_addr_q  <= dph_addr_d;
            dph_mask_q  <= dph_mask_d;
            wbuf_vld_q  <= wbuf_vld_d;
            wbuf_addr_q <= wbuf_addr_d;
            wbuf_mask_q <= wbuf_mask_d;
            wbuf_data_q <= wbuf_data_d;
            fwd_mask_q  <= fwd_mask_d;
        end
    end

endmodule

// File: doc/ahbl_gf_sram_ctrl.md
# ahbl_gf_sram_ctrl

AHB-Lite subordinate that fronts one 2 KiB bank built from four 512x8 GF180 SRAM macros, one macro per byte lane. It drives the macros' shared CEN/GWEN/A and per-bit WEN/D directly, and returns their registered Q as HRDATA. Reads and writes run with zero wait states. A one-entry write buffer resolves the port conflict between a write's data phase and a following read's address phase.

## Interface
Parameters:
- W_ADDR, default 32: AHB address width. Only bits [10:0] are decoded; higher bits alias.

Ports:
- clk  in  1  system clock; the macros share this clock.
- rst  in  1  asynchronous, active-high reset.
- ahbls_hready  in  1  bus-level HREADY.
- ahbls_hready_resp  out  1  tied to 1.
- ahbls_hresp  out  1  tied to 0.
- ahbls_haddr  in  W_ADDR  address.
- ahbls_hwrite  in  1  transfer direction.
- ahbls_htrans  in  2  transfer type.
- ahbls_hsize  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- ahbls_hburst, ahbls_hprot, ahbls_hmastlock  in  3/4/1  ignored.
- ahbls_hwdata  in  32  write data.
- ahbls_hrdata  out  32  read data.
- sram_cen  out  1  active-low chip enable, common to all four macros.
- sram_gwen  out  1  active-low global write enable, common.
- sram_wen  out  32  active-low per-bit write enable; lane n drives macro n WEN[7:0].
- sram_a  out  9  word address, equal to haddr[10:2].
- sram_d  out  32  write data.
- sram_q  in  32  macro Q outputs; each Q updates only on a read cycle.

## Operation
- Address phase is valid when ahbls_hready & htrans[1]. Misaligned transfers and hsize > 2 are undefined.
- Byte mask from hsize/haddr[1:0]:
  - byte: the single lane haddr[1:0].
  - half: lanes {haddr[1],1'b0}+{0,1}.
  - word: all four lanes.
- State: dph_write (write data phase pending), dph_addr[8:0], dph_mask[3:0], wbuf_vld, wbuf_addr, wbuf_mask, wbuf_data[31:0], fwd_mask[3:0].
- SRAM port arbitration each cycle, highest priority first:
  1. Read address phase: cen=0, gwen=1, a=haddr[10:2].
  2. wbuf_vld: write wbuf_data under wbuf_mask at wbuf_addr, then clear wbuf_vld.
  3. Write data phase: write ahbls_hwdata under dph_mask at dph_addr. sram_d is driven combinationally from hwdata.
  4. Otherwise: cen=1, gwen=1, wen all 1s.
- A write data phase that collides with a read address phase loads wbuf from hwdata/dph_* at the cycle end.
- Invariant: wbuf_vld=0 whenever a write data phase begins. The cycle holding its address phase has no read address phase and no write data phase, so the buffer drains in that cycle. The bench asserts this invariant.
- Read forwarding:
  - At a read address phase, fwd_mask is set to the buffered mask if the word address matches a live wbuf, or matches a write data phase that is being deferred this cycle. Otherwise fwd_mask is 0.
  - hrdata = (sram_q & ~lanemask(fwd_mask)) | (wbuf_data & lanemask(fwd_mask)).
  - wbuf_data keeps its value after draining, so forwarding stays correct in the drain cycle.
- WEN per bit: 0 where the lane mask bit is set, 1 elsewhere. gwen=0 only on write cycles.

## Timing
- Read: address phase at cycle N drives the macro. Q is valid in the data phase at N+1; hrdata is combinational from Q.
- Write: committed in its data-phase cycle, or buffered and committed in the first later cycle with no read address phase.
- Back-to-back read/write/read sequences never stall, and HREADY is never deasserted.
- ahbls_hready low: the address phase is not sampled and no SRAM read is issued. A pending wbuf may still drain.
- Reset values: dph_write=0, wbuf_vld=0, fwd_mask=0, wbuf_data=0, wbuf_addr=0, wbuf_mask=0.
- Outputs during reset: sram_cen=1, sram_gwen=1, sram_wen=all 1s, hready_resp=1, hresp=0.
- Reset mid-operation: a buffered or in-flight write is dropped and the SRAM contents are left unchanged.

## Structure
- Shared package holds:
  - HTRANS and HSIZE encodings.
  - SRAM geometry constants: macro depth 512, 4 lanes, word address width 9.
  - The lane-mask decode function.
- No internal sub-module.
- The four macro instances and this controller are placed together in wrapper ahbl_gf_sram_2k.

## Test plan
- Word write 0x100 = 0xDEADBEEF, then read 0x100. Expect hrdata 0xDEADBEEF, no wait states.
- Byte writes 0x11 at 0x201 and 0x22 at 0x202 over a word preloaded with 0xAABBCCDD, then word read. Expect 0xAA2211DD.
- Write 0x300 = 0x12345678 immediately followed by a read of 0x300. The write is buffered and forwarded: hrdata 0x12345678. The drain is seen on the following idle cycle.
- Half-write 0xBEEF at 0x402 buffered while reads to 0x404, 0x408 and 0x402 follow back-to-back. The write stays buffered throughout. Expect correct data for each read, and the 0x402 read returns 0xBEEF in the upper half. The buffer drains on the first non-read cycle.
- Assert rst while wbuf_vld=1. Expect sram_cen=1 and wbuf_vld=0 immediately. A later read returns the pre-write contents.
- Random AHB-Lite traffic with idle cycles and ahbls_hready low cycles against a scoreboard. Expect zero mismatches and the wbuf invariant never violated.
